md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations, owns the HI/LO architectural registers and a pending-result buffer, and models fixed-latency execution with an FSM and countdown counter. Raises a stall request to the hazard unit whenever a new HI/LO operation arrives while an operation is still in flight. Sits beside the ALU in EX; `rd_data` feeds the EX result mux for MFHI/MFLO.

---
 rtl/md_sequencer_pkg.sv | 14 +
 rtl/md_sequencer_arith.sv | 30 +++
 rtl/md_sequencer.sv | 67 ++++++
 tb/tb_md_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: op codes, FSM encoding and default latencies for the HI/LO sequencer
package md_sequencer_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} md_state_e;
endpackage

// File: rtl/md_sequencer_arith.sv
// md_arith: combinational 64-bit product and quotient/remainder with div-by-zero and overflow rules
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);
  logic        is_mul, sx, ovf;
  logic [31:0] db, sq, sr, uq, ur;
  logic [63:0] prod;
  // One 64-bit multiplier serves both signednesses via operand extension; the divisor is
  // forced to 1 on zero/overflow so the dividers never see an undefined case and the
  // overflow result (quotient = dividend, remainder 0) falls out naturally.
  always_comb begin
    is_mul = op == MD_MULT || op == MD_MULTU;
    sx = op == MD_MULT;
    prod = {{32{sx & a[31]}}, a} * {{32{sx & b[31]}}, b};
    ovf = op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    db = (b == 32'd0 || ovf) ? 32'd1 : b;
    sq = $signed(a) / $signed(db);
    sr = $signed(a) % $signed(db);
    uq = a / db;
    ur = a % db;
    res_hi = is_mul ? prod[63:32] : b == 32'd0 ? a : op == MD_DIV ? sr : ur;
    res_lo = is_mul ? prod[31:0] : b == 32'd0 ? 32'hFFFF_FFFF : op == MD_DIV ? sq : uq;
  end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: fixed-latency multiply/divide sequencer owning HI/LO with stall request
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] rd_data,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);
  localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;
  md_state_e     state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   res_hi, res_lo, a_hi, a_lo;
  logic          accept, is_mul, is_div;
  md_arith u_arith (.op(op), .a(rs_data), .b(rt_data), .res_hi(a_hi), .res_lo(a_lo));
  assign accept = op_valid & ~flush & ~stall_req;
  assign is_mul = op == MD_MULT || op == MD_MULTU;
  assign is_div = op == MD_DIV || op == MD_DIVU;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nx;
  // next state: leave IDLE on an accepted arithmetic op, return once the countdown expires
  always_comb begin
    state_nx = state == ST_IDLE ? (accept && is_mul ? ST_MUL : accept && is_div ? ST_DIV : ST_IDLE)
             : cnt == '0 ? ST_IDLE : state;
  end
  // outputs: busy/stall and the MFHI/MFLO read port, which only answers when idle
  always_comb begin
    busy = state != ST_IDLE;
    stall_req = op_valid & busy;
    rd_data = !op_valid || busy ? 32'd0 : op == MD_MFHI ? hi_q : op == MD_MFLO ? lo_q : 32'd0;
  end
  // pending result, countdown and architectural HI/LO; reset drops any in-flight result
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_IDLE) begin
      if (accept && (is_mul || is_div)) begin
        res_hi <= a_hi;
        res_lo <= a_lo;
        cnt <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
      end
      if (accept && op == MD_MTHI) hi_q <= rs_data;
      if (accept && op == MD_MTLO) lo_q <= rs_data;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: randomized and directed checks of md_sequencer against a cycle-count reference model
module tb_md_sequencer;
  localparam int NM = 5;
  localparam int ND = 10;
  logic        clk = 1'b0;
  logic        reset, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, stall_req;
  logic [31:0] rd_data, hi_q, lo_q;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          left = 0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .stall_req(stall_req),
    .rd_data(rd_data), .hi_q(hi_q), .lo_q(lo_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {hi,lo} from the architectural definition, using 64-bit integer arithmetic
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: r = sa * sb;
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // one cycle: drive, compare every output with the model, then advance the model across the edge
  task automatic step(input logic v, input logic [2:0] o, input logic f, input logic [31:0] a, input logic [31:0] b);
    logic eb;
    logic [31:0] erd;
    @(negedge clk);
    op_valid = v; op = o; flush = f; rs_data = a; rt_data = b;
    #1;
    eb = left > 0;
    erd = (v && !eb && o == 3'd6) ? m_hi : (v && !eb && o == 3'd7) ? m_lo : 32'd0;
    chk("busy", 32'(busy), 32'(eb));
    chk("stall_req", 32'(stall_req), 32'(v & eb));
    chk("rd_data", rd_data, erd);
    chk("hi_q", hi_q, m_hi);
    chk("lo_q", lo_q, m_lo);
    if (left > 0) begin
      left--;
      if (left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (v && !f) begin
      if (o < 3'd4) begin
        {p_hi, p_lo} = ref_res(o, a, b);
        left = (o < 3'd2) ? NM : ND;
      end else if (o == 3'd4) m_hi = a;
      else if (o == 3'd5) m_lo = a;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rnd_opnd();
    int k;
    k = $urandom_range(0, 9);
    return k == 0 ? 32'd0 : k == 1 ? 32'h8000_0000 : k == 2 ? 32'hFFFF_FFFF : k == 3 ? 32'($urandom_range(0, 20)) : $urandom;
  endfunction

  initial begin
    int stalls;
    bit done;
    reset = 1'b0; op_valid = 1'b1; op = 3'd6; flush = 1'b0; rs_data = 0; rt_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_hi", hi_q, 0);
    chk("rst_lo", lo_q, 0);
    reset = 1'b1;

    step(1, 3'd0, 0, 32'hFFFF_FFFE, 32'd3);
    idle(NM + 1);
    chk("mult_hi", hi_q, 32'hFFFF_FFFF);
    chk("mult_lo", lo_q, 32'hFFFF_FFFA);
    step(1, 3'd1, 0, 32'hFFFF_FFFE, 32'd3);
    idle(NM + 1);
    chk("multu_hi", hi_q, 32'd2);
    chk("multu_lo", lo_q, 32'hFFFF_FFFA);
    step(1, 3'd2, 0, 32'hFFFF_FFF9, 32'd2);
    idle(ND + 1);
    chk("div_hi", hi_q, 32'hFFFF_FFFF);
    chk("div_lo", lo_q, 32'hFFFF_FFFD);
    step(1, 3'd3, 0, 32'd7, 32'd0);
    idle(ND + 1);
    chk("divu0_hi", hi_q, 32'd7);
    chk("divu0_lo", lo_q, 32'hFFFF_FFFF);
    step(1, 3'd2, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(ND + 1);
    chk("divovf_hi", hi_q, 32'd0);
    chk("divovf_lo", lo_q, 32'h8000_0000);

    step(1, 3'd0, 0, 32'd5, 32'd7);
    stalls = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 3'd7, 0, 0, 0);
      if (stall_req) stalls++;
      else begin chk("mflo_rd", rd_data, 32'd35); done = 1; end
    end
    if (!done) chk("mflo_timeout", 0, 1);
    chk("mflo_stalls", stalls, NM);

    step(1, 3'd4, 0, 32'h1234_5678, 0);
    step(1, 3'd6, 0, 0, 0);
    chk("mfhi_rd", rd_data, 32'h1234_5678);

    step(1, 3'd0, 0, 32'd3, 32'd4);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 3'd5, 0, 32'h0000_CAFE, 0);
      if (!stall_req) begin chk("mtlo_pre", lo_q, 32'd12); done = 1; end
    end
    if (!done) chk("mtlo_timeout", 0, 1);
    step(0, 3'd0, 0, 0, 0);
    chk("mtlo_post", lo_q, 32'h0000_CAFE);

    step(1, 3'd0, 1, 32'd9, 32'd9);
    step(0, 3'd0, 0, 0, 0);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_lo", lo_q, 32'h0000_CAFE);

    step(1, 3'd2, 0, 32'd100, 32'd3);
    idle(3);
    @(negedge clk);
    op_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_hi", hi_q, 0);
    chk("arst_lo", lo_q, 0);
    m_hi = 0; m_lo = 0; left = 0;
    #1 reset = 1'b1;
    idle(ND + 2);
    chk("arst_nocommit", lo_q, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, rnd_opnd(), rnd_opnd());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
